// File: rtl/rf_writeback_scheduler_if.sv
// Bundle of producer handshakes, decode hazard query and register file write
// port seen by rf_writeback_scheduler.
//
// Handshake semantics (alu_* and lsu_*): a producer raises valid with dst/data
// and holds all three stable until it sees ready=1 in the same cycle; the
// transfer happens at the rising clk edge where valid && ready. ready is a pure
// function of the valid inputs and the internal priority pointer, never of
// another ready.
interface rf_writeback_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_dst;
    logic [DATA_W-1:0] lsu_data;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dst;
    logic [ADDR_W-1:0] rs_1;
    logic [ADDR_W-1:0] rs_2;
    logic              stall;
    logic [NREG-1:0]   busy;

    logic              rf_write;
    logic [ADDR_W-1:0] rf_dst;
    logic [DATA_W-1:0] rf_data;

    // Debug view of the round-robin pointer: 1 = LSU preferred next.
    logic              pref_lsu;

    modport master (
        output alu_valid, alu_dst, alu_data,
        output lsu_valid, lsu_dst, lsu_data,
        output issue_valid, issue_dst, rs_1, rs_2,
        input  alu_ready, lsu_ready, stall, busy,
        input  rf_write, rf_dst, rf_data, pref_lsu
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data,
        input  lsu_valid, lsu_dst, lsu_data,
        input  issue_valid, issue_dst, rs_1, rs_2,
        output alu_ready, lsu_ready, stall, busy,
        output rf_write, rf_dst, rf_data, pref_lsu
    );
endinterface

// File: rtl/rf_writeback_scheduler.sv
// Writeback scheduler: round-robin arbitration of ALU and LSU results onto the
// single register file write port, a per-register busy scoreboard and the
// decode-stage RAW/WAW stall. Commits appear on the write port one cycle after
// the handshake; writes to x0 are accepted but dropped.
module rf_writeback_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input logic                    clk,
    input logic                    rst,
    rf_writeback_scheduler_if.slave bus
);
    localparam logic [0:0] PREF_ALU = 1'b0;
    localparam logic [0:0] PREF_LSU = 1'b1;

    logic [0:0]        pref;
    logic              grant_alu;
    logic              grant_lsu;
    logic              grant_any;
    logic [ADDR_W-1:0] grant_dst;
    logic [DATA_W-1:0] grant_data;
    logic              commit_live;

    logic              rf_write_q;
    logic [ADDR_W-1:0] rf_dst_q;
    logic [DATA_W-1:0] rf_data_q;

    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_next;
    logic              stall_rs_1;
    logic              stall_rs_2;
    logic              stall_waw;

    // Round-robin grant; nothing is granted while reset is held.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && (!bus.lsu_valid || pref == PREF_ALU)) begin
                grant_alu = 1'b1;
            end else if (bus.lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    // Select the winning producer's payload; x0 results are accepted but not committed.
    always_comb begin
        grant_any   = grant_alu | grant_lsu;
        grant_dst   = grant_lsu ? bus.lsu_dst  : bus.alu_dst;
        grant_data  = grant_lsu ? bus.lsu_data : bus.alu_data;
        commit_live = grant_any && (grant_dst != '0);
    end

    // Scoreboard next state: clear on the write port edge, then issue sets (set wins).
    always_comb begin
        busy_next = busy_q;
        if (rf_write_q) begin
            busy_next[rf_dst_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_dst != '0)) begin
            busy_next[bus.issue_dst] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Pointer, output register and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pref       <= PREF_ALU;
            rf_write_q <= 1'b0;
            rf_dst_q   <= '0;
            rf_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            if (grant_any) begin
                pref <= grant_alu ? PREF_LSU : PREF_ALU;
            end
            rf_write_q <= commit_live;
            if (commit_live) begin
                rf_dst_q  <= grant_dst;
                rf_data_q <= grant_data;
            end
            busy_q <= busy_next;
        end
    end

    // Decode hazard: no bypass, so a source stays stalled until busy clears.
    always_comb begin
        stall_rs_1 = (bus.rs_1 != '0) && busy_q[bus.rs_1];
        stall_rs_2 = (bus.rs_2 != '0) && busy_q[bus.rs_2];
        stall_waw  = bus.issue_valid && (bus.issue_dst != '0) && busy_q[bus.issue_dst];
    end

    assign bus.alu_ready = grant_alu;
    assign bus.lsu_ready = grant_lsu;
    assign bus.stall     = stall_rs_1 | stall_rs_2 | stall_waw;
    assign bus.busy      = busy_q;
    assign bus.rf_write  = rf_write_q;
    assign bus.rf_dst    = rf_dst_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.pref_lsu  = (pref == PREF_LSU);
endmodule
